// File: rtl/regfile_sb_if.sv
// Bundled register-file access bus: read ports, write ports, scoreboard reserve/flush.
// master drives requests (decode/writeback side), slave is the register file.
interface regfile_sb_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned RD_PORTS  = 2,
  parameter int unsigned WR_PORTS  = 1
);
  localparam int unsigned AW = $clog2(REG_COUNT);

  logic [RD_PORTS-1:0]      rd_en;
  logic [RD_PORTS*AW-1:0]   rd_addr;
  logic [RD_PORTS*XLEN-1:0] rd_data;
  logic [RD_PORTS-1:0]      rd_ready;
  logic [WR_PORTS-1:0]      wr_en;
  logic [WR_PORTS*AW-1:0]   wr_addr;
  logic [WR_PORTS*XLEN-1:0] wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic                     rsv_ok;
  logic                     flush;
  logic                     busy_any;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_ready, rsv_ok, busy_any
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_ready, rsv_ok, busy_any
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and per-register pending-write counters.
// The scoreboard is compiled in only when REGFILE_SCOREBOARD_EN is defined.
module regfile_sb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned RD_PORTS  = 2,
  parameter int unsigned WR_PORTS  = 1,
  parameter int unsigned PEND_W    = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(REG_COUNT);

  logic [REG_COUNT-1:0]     wr_hit;
  logic [XLEN-1:0]          wr_val [REG_COUNT];
  logic [XLEN-1:0]          regs_q [REG_COUNT];
  logic [AW-1:0]            ra     [RD_PORTS];
  logic [RD_PORTS-1:0]      rd_live;
  logic [RD_PORTS*XLEN-1:0] rd_data_d;
  logic [RD_PORTS-1:0]      rd_ready_d;

  // Per-register write decode; ascending port order makes the highest port win a collision.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < REG_COUNT; r++) wr_val[r] = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (!rst && bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0)) begin
        wr_hit[bus.wr_addr[p*AW +: AW]] = 1'b1;
        wr_val[bus.wr_addr[p*AW +: AW]] = bus.wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_val[r];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_live   = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      ra[i]      = bus.rd_addr[i*AW +: AW];
      rd_live[i] = !rst && bus.rd_en[i] && (ra[i] != '0);
      if (rd_live[i]) begin
        rd_data_d[i*XLEN +: XLEN] = wr_hit[ra[i]] ? wr_val[ra[i]] : regs_q[ra[i]];
      end
    end
  end

  assign bus.rd_data = rd_data_d;

`ifdef REGFILE_SCOREBOARD_EN
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [PEND_W-1:0]    pend_q [REG_COUNT];
  logic [PEND_W-1:0]    pend_d [REG_COUNT];
  logic [REG_COUNT-1:0] pend_nz;
  logic                 rsv_ok;

  // Entry 0 is never reserved, so x0 reservations short-circuit to accepted.
  assign rsv_ok = !rst && !bus.flush && bus.rsv_en &&
                  ((bus.rsv_addr == '0) || (pend_q[bus.rsv_addr] != PMAX));

  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      pend_d[r]  = '0;
      pend_nz[r] = (pend_q[r] != '0);
    end
    for (int r = 1; r < REG_COUNT; r++) begin
      pend_d[r] = pend_q[r] + PEND_W'(rsv_ok && (bus.rsv_addr == AW'(r)))
                            - PEND_W'(wr_hit[r] && pend_nz[r]);
      if (bus.flush) pend_d[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) pend_q[r] <= pend_d[r];
    end
  end

  // Ready when nothing is in flight or the last outstanding writer lands this cycle.
  always_comb begin
    rd_ready_d = '1;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_ready_d[i] = !rd_live[i] || !pend_nz[ra[i]] ||
                      ((pend_q[ra[i]] == PEND_W'(1)) && wr_hit[ra[i]]);
    end
  end

  assign bus.rsv_ok   = rsv_ok;
  assign bus.busy_any = |pend_nz;
`else
  logic unused_sb;

  assign unused_sb    = ^{bus.rsv_en, bus.rsv_addr, bus.flush, rd_live};
  assign rd_ready_d   = '1;
  assign bus.rsv_ok   = !rst;
  assign bus.busy_any = 1'b0;
`endif

  assign bus.rd_ready = rd_ready_d;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; expectations adapt to whether REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_sb;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned RD_PORTS  = 2;
  localparam int unsigned WR_PORTS  = 2;
  localparam int unsigned PEND_W    = 2;
  localparam int unsigned AW        = 5;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  // Expected values that differ between the scoreboard and plain builds.
  localparam logic [31:0] PEND_RDY = SB ? 32'd0 : 32'd1;
  localparam logic [31:0] BUSY     = SB ? 32'd1 : 32'd0;
  localparam logic [31:0] REJ_OK   = SB ? 32'd0 : 32'd1;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  regfile_sb_if #(
    .XLEN(XLEN), .REG_COUNT(REG_COUNT), .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS)
  ) bus ();

  regfile_sb #(
    .XLEN(XLEN), .REG_COUNT(REG_COUNT), .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS),
    .PEND_W(PEND_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  // Inputs change on the falling edge and hold across the next rising edge.
  task automatic start_cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input int p, input int a);
    bus.rd_en[p]             = 1'b1;
    bus.rd_addr[p*AW +: AW]  = AW'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.wr_en[p]               = 1'b1;
    bus.wr_addr[p*AW +: AW]    = AW'(a);
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  function automatic logic [31:0] rdata(input int p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] rready(input int p);
    return {31'b0, bus.rd_ready[p]};
  endfunction

  function automatic logic [31:0] rsv_ok();
    return {31'b0, bus.rsv_ok};
  endfunction

  function automatic logic [31:0] busy();
    return {31'b0, bus.busy_any};
  endfunction

  initial begin
    idle();
    rst = 1'b1;

    // Held in reset: traffic ignored, outputs forced.
    start_cyc(); rd(0, 5); rd(1, 9); wr(0, 5, 32'hAA); rsv(1); #1;
    check_eq("rst_rdata", rdata(0), 32'h0);
    check_eq("rst_ready", {30'b0, bus.rd_ready}, 32'h3);
    check_eq("rst_rsv_ok", rsv_ok(), 32'h0);

    // First cycle out of reset.
    start_cyc(); rst = 1'b0; rd(0, 5); rsv(0); #1;
    check_eq("post_rst_x5", rdata(0), 32'h0);
    check_eq("post_rst_rsv_x0", rsv_ok(), 32'h1);
    check_eq("post_rst_busy", busy(), 32'h0);

    for (int a = 0; a < 32; a++) begin
      start_cyc(); rd(0, a); rd(1, 31 - a); #1;
      check_eq($sformatf("clr_p0_x%0d", a), rdata(0), 32'h0);
      check_eq($sformatf("clr_p1_x%0d", 31 - a), rdata(1), 32'h0);
      if (a == 0) check_eq("busy_after_x0_rsv", busy(), 32'h0);
    end

    // x0 ignores writes, including via bypass.
    start_cyc(); wr(0, 0, 32'hDEADBEEF); rd(0, 0); #1;
    check_eq("x0_bypass", rdata(0), 32'h0);
    start_cyc(); rd(0, 0); #1;
    check_eq("x0_stored", rdata(0), 32'h0);

    // Same-cycle collision: port 1 wins for bypass and storage.
    start_cyc(); wr(0, 5, 32'h11); wr(1, 5, 32'h22); rd(0, 5); rd(1, 6); #1;
    check_eq("coll_bypass", rdata(0), 32'h22);
    check_eq("coll_other", rdata(1), 32'h0);
    start_cyc(); wr(0, 6, 32'h33); rd(0, 5); rd(1, 6); #1;
    check_eq("coll_stored", rdata(0), 32'h22);
    check_eq("p0_bypass_x6", rdata(1), 32'h33);
    start_cyc(); rd(1, 6); #1;
    check_eq("p0_stored_x6", rdata(1), 32'h33);

    // Two writers in flight on x7.
    start_cyc(); rsv(7); #1; check_eq("rsv7_a", rsv_ok(), 32'h1);
    start_cyc(); rsv(7); #1; check_eq("rsv7_b", rsv_ok(), 32'h1);
    start_cyc(); rd(0, 7); bus.rd_addr[AW +: AW] = AW'(7); #1;
    check_eq("x7_pend2_ready", rready(0), PEND_RDY);
    check_eq("x7_disabled_port_ready", rready(1), 32'h1);
    check_eq("x7_disabled_port_data", rdata(1), 32'h0);
    check_eq("x7_busy", busy(), BUSY);
    start_cyc(); wr(1, 7, 32'h77); rd(0, 7); #1;
    check_eq("x7_wr1_ready", rready(0), PEND_RDY);
    check_eq("x7_wr1_data", rdata(0), 32'h77);
    start_cyc(); wr(1, 7, 32'h78); rd(0, 7); #1;
    check_eq("x7_wr2_ready", rready(0), 32'h1);
    check_eq("x7_wr2_data", rdata(0), 32'h78);
    check_eq("x7_wr2_busy", busy(), BUSY);
    start_cyc(); rd(0, 7); #1;
    check_eq("x7_done_data", rdata(0), 32'h78);
    check_eq("x7_done_ready", rready(0), 32'h1);
    check_eq("x7_done_busy", busy(), 32'h0);

    // Counter saturation on x3 and net-zero reserve+write.
    for (int k = 0; k < 3; k++) begin
      start_cyc(); rsv(3); #1; check_eq($sformatf("rsv3_%0d", k), rsv_ok(), 32'h1);
    end
    start_cyc(); rsv(3); #1; check_eq("rsv3_full", rsv_ok(), REJ_OK);
    start_cyc(); rd(0, 3); #1; check_eq("x3_full_ready", rready(0), PEND_RDY);
    start_cyc(); wr(0, 3, 32'h3A); rd(0, 3); #1;
    check_eq("x3_wr_pend3_ready", rready(0), PEND_RDY);
    start_cyc(); wr(0, 3, 32'h3B); rsv(3); #1;
    check_eq("x3_rsv_wr_ok", rsv_ok(), 32'h1);
    start_cyc(); rsv(3); #1; check_eq("x3_refill", rsv_ok(), 32'h1);
    start_cyc(); rsv(3); #1; check_eq("x3_full_again", rsv_ok(), REJ_OK);
    start_cyc(); bus.flush = 1'b1; #1;
    start_cyc(); rd(0, 3); #1;
    check_eq("x3_flushed_busy", busy(), 32'h0);
    check_eq("x3_flushed_ready", rready(0), 32'h1);
    check_eq("x3_data", rdata(0), 32'h3B);

    // Flush discards pending counts and a same-cycle reserve; writes still land.
    start_cyc(); rsv(9); #1;
    start_cyc(); rsv(10); #1;
    start_cyc(); rd(0, 9); #1;
    check_eq("x9_pending_ready", rready(0), PEND_RDY);
    check_eq("pre_flush_busy", busy(), BUSY);
    start_cyc(); bus.flush = 1'b1; rsv(11); wr(0, 12, 32'hF1); #1;
    check_eq("flush_rsv_ok", rsv_ok(), REJ_OK);
    start_cyc(); rd(0, 11); rd(1, 12); #1;
    check_eq("post_flush_busy", busy(), 32'h0);
    check_eq("x11_ready", rready(0), 32'h1);
    check_eq("x12_flush_write", rdata(1), 32'hF1);
    start_cyc(); rd(0, 9); rd(1, 10); #1;
    check_eq("x9_ready_after_flush", rready(0), 32'h1);
    check_eq("x10_ready_after_flush", rready(1), 32'h1);

    // Reset mid-operation with x4 pending.
    start_cyc(); wr(0, 4, 32'h44); #1;
    start_cyc(); rsv(4); #1; check_eq("rsv4", rsv_ok(), 32'h1);
    start_cyc(); rd(0, 4); #1;
    check_eq("x4_pending_ready", rready(0), PEND_RDY);
    check_eq("x4_pre_rst_data", rdata(0), 32'h44);
    start_cyc(); rst = 1'b1; wr(0, 4, 32'h99); rsv(4); rd(0, 4); #1;
    check_eq("midrst_data", rdata(0), 32'h0);
    check_eq("midrst_ready", rready(0), 32'h1);
    check_eq("midrst_rsv_ok", rsv_ok(), 32'h0);
    start_cyc(); rst = 1'b0; rd(0, 4); #1;
    check_eq("x4_after_rst_data", rdata(0), 32'h0);
    check_eq("x4_after_rst_ready", rready(0), 32'h1);
    check_eq("after_rst_busy", busy(), 32'h0);
    start_cyc(); wr(1, 4, 32'h55); rd(0, 4); #1;
    check_eq("x4_floor_ready", rready(0), 32'h1);
    start_cyc(); rd(0, 4); #1;
    check_eq("x4_floor_busy", busy(), 32'h0);
    check_eq("x4_floor_data", rdata(0), 32'h55);

    // Reserve x2 then read it on both ports.
    start_cyc(); rsv(2); #1; check_eq("rsv2", rsv_ok(), 32'h1);
    start_cyc(); rd(0, 2); rd(1, 2); #1;
    check_eq("x2_ready_p0", rready(0), PEND_RDY);
    check_eq("x2_ready_p1", rready(1), PEND_RDY);
    check_eq("x2_busy", busy(), BUSY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
